// File: rtl/xup_debounce4.sv
// Four-channel switch debouncer: two-flop synchronizer per channel, a per-channel
// stability counter, and registered level, edge-pulse and OR-summary outputs.
module xup_debounce4 #(
  parameter int STABLE_COUNT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] y,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic       any
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

  logic [3:0]                raw_s;
  logic [3:0]                s1_q;
  logic [3:0]                s2_q;
  logic [3:0]                y_q;
  logic [3:0]                y_d;
  logic [3:0]                rise_q;
  logic [3:0]                rise_d;
  logic [3:0]                fall_q;
  logic [3:0]                fall_d;
  logic                      any_q;
  logic                      any_d;
  logic [3:0][CNT_WIDTH-1:0] cnt_q;
  logic [3:0][CNT_WIDTH-1:0] cnt_d;

  assign raw_s = {d, c, b, a};

  // Per-channel stability counting; the output only follows after an unbroken run.
  always_comb begin
    y_d   = y_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] != y_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          y_d[i]   = s2_q[i];
          cnt_d[i] = CNT_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        cnt_d[i] = CNT_ZERO;
      end
    end
  end

  // Pulses and the OR summary come from next-state y so they land with y itself.
  always_comb begin
    rise_d = y_d & ~y_q;
    fall_d = ~y_d & y_q;
    any_d  = |y_d;
  end

  // All state registers, cleared together by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 4'b0000;
      s2_q   <= 4'b0000;
      y_q    <= 4'b0000;
      rise_q <= 4'b0000;
      fall_q <= 4'b0000;
      any_q  <= 1'b0;
      cnt_q  <= {4{CNT_ZERO}};
    end else begin
      s1_q   <= raw_s;
      s2_q   <= s1_q;
      y_q    <= y_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y    = y_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign any  = any_q;

endmodule
